// File: rtl/cnn_input_loader_if.sv
// cnn_input_loader_if: input word stream plus 1-cycle read port of the input loader
interface cnn_input_loader_if #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_W    = 10
);
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_SIZE-1:0] in_data;
    logic                 in_last;
    logic                 rd_en;
    logic [ADDR_W-1:0]    rd_addr;
    logic [DATA_SIZE-1:0] rd_data;

    modport master (
        output in_valid, in_data, in_last, rd_en, rd_addr,
        input  in_ready, rd_data
    );

    modport slave (
        input  in_valid, in_data, in_last, rd_en, rd_addr,
        output in_ready, rd_data
    );
endinterface

// File: rtl/cnn_input_loader.sv
// cnn_input_loader: buffers a framed image+kernel word stream and serves it to conv_layer
module cnn_input_loader #(
    parameter int DATA_SIZE   = 32,
    parameter int DATA_X      = 28,
    parameter int DATA_Y      = 28,
    parameter int WEIGHT_X    = 5,
    parameter int WEIGHT_Y    = 5,
    parameter int NUM_KERNELS = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      clear,
    cnn_input_loader_if.slave         bus,
    output logic                      conv_enable,
    output logic                      error,
    output logic                      busy
);
    localparam int IMG_WORDS = DATA_X * DATA_Y;
    localparam int WGT_WORDS = WEIGHT_X * WEIGHT_Y * NUM_KERNELS;
    localparam int TOTAL     = IMG_WORDS + WGT_WORDS;
    localparam int ADDR_W    = $clog2(TOTAL);
    localparam logic [ADDR_W-1:0] LAST_IMG = ADDR_W'(IMG_WORDS - 1);
    localparam logic [ADDR_W-1:0] LAST_ALL = ADDR_W'(TOTAL - 1);

    typedef enum logic [2:0] {IDLE, LOAD_IMG, LOAD_WGT, DONE, ERR} state_t;

    state_t               state;
    logic [ADDR_W-1:0]    cnt;
    logic [DATA_SIZE-1:0] mem [TOTAL];
    logic                 acc;
    logic                 at_end;

    assign acc    = bus.in_valid & bus.in_ready;
    assign at_end = cnt == LAST_ALL;

    always_ff @(posedge clk) begin
        if (acc) mem[cnt] <= bus.in_data;
    end

    // Non-blocking read of mem gives read-before-write on a same-cycle collision
    always_ff @(posedge clk) begin
        if (rst) bus.rd_data <= '0;
        else if (bus.rd_en) bus.rd_data <= (bus.rd_addr < ADDR_W'(TOTAL)) ? mem[bus.rd_addr] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            bus.in_ready <= 1'b0;
            busy         <= 1'b0;
            conv_enable  <= 1'b0;
            error        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state        <= LOAD_IMG;
                    cnt          <= '0;
                    bus.in_ready <= 1'b1;
                    busy         <= 1'b1;
                end
                LOAD_IMG, LOAD_WGT: if (acc) begin
                    cnt <= cnt + 1'b1;
                    if (bus.in_last != at_end) begin
                        state        <= ERR;
                        bus.in_ready <= 1'b0;
                        busy         <= 1'b0;
                        error        <= 1'b1;
                    end else if (at_end) begin
                        state        <= DONE;
                        bus.in_ready <= 1'b0;
                        busy         <= 1'b0;
                        conv_enable  <= 1'b1;
                    end else if (cnt == LAST_IMG) begin
                        state <= LOAD_WGT;
                    end
                end
                DONE: if (clear) begin
                    state       <= IDLE;
                    conv_enable <= 1'b0;
                end
                ERR: if (clear) begin
                    state <= IDLE;
                    error <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cnn_input_loader.sv
// tb_cnn_input_loader: directed self-checking bench for the input loader
module tb_cnn_input_loader;
    logic clk = 1'b0;
    logic rst, start, clear;
    logic conv_enable, error, busy;
    int   n_cmp = 0;
    int   n_err = 0;
    logic ce_seen;

    always #5 clk = ~clk;

    cnn_input_loader_if #(.DATA_SIZE(32), .ADDR_W(10)) bus ();

    cnn_input_loader dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .bus(bus),
        .conv_enable(conv_enable), .error(error), .busy(busy)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    task automatic rd(input int addr, input logic [31:0] exp, input string tag);
        bus.rd_en   = 1'b1;
        bus.rd_addr = 10'(addr);
        cyc();
        bus.rd_en = 1'b0;
        chk(tag, bus.rd_data, exp);
    endtask

    // Drives n accepted beats (data = index ^ xr); gap>0 drops in_valid every gap-th cycle
    task automatic stream(input int n, input int last_at, input int gap, input logic [31:0] xr, input int start_at);
        int   i = 0;
        int   c = 0;
        logic acc;
        ce_seen = 1'b0;
        while (i < n && c < 4000) begin
            bus.in_valid = !(gap > 0 && c % gap == gap - 1);
            bus.in_data  = 32'(i) ^ xr;
            bus.in_last  = (i == last_at);
            start        = (i == start_at);
            acc          = bus.in_valid && bus.in_ready;
            if (conv_enable) ce_seen = 1'b1;
            cyc();
            c++;
            if (acc) i++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        start        = 1'b0;
        chk("stream_beats", 32'(i), 32'(n));
    endtask

    task automatic beat(input logic [31:0] d, input logic last);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        cyc();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; clear = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
        bus.rd_en = 1'b0; bus.rd_addr = '0;
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_conv_enable", 32'(conv_enable), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rd_data", bus.rd_data, 0);
        bus.in_valid = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        chk("idle_no_accept", 32'(busy), 0);

        pulse_start();
        chk("s1_busy", 32'(busy), 1);
        chk("s1_ready", 32'(bus.in_ready), 1);
        stream(984, 983, 0, 32'h0, -1);
        chk("s1_ce_early", 32'(ce_seen), 0);
        chk("s1_ce", 32'(conv_enable), 1);
        chk("s1_ready_low", 32'(bus.in_ready), 0);
        chk("s1_busy_low", 32'(busy), 0);
        rd(0, 32'd0, "s1_rd0");
        rd(784, 32'd784, "s1_rd784");
        rd(983, 32'd983, "s1_rd983");
        cyc();
        chk("s1_rd_hold", bus.rd_data, 32'd983);
        rd(1000, 32'd0, "s1_rd1000");
        pulse_start();
        chk("s1_start_in_done", 32'(conv_enable), 1);
        pulse_clear();
        chk("s1_clear_ce", 32'(conv_enable), 0);

        pulse_start();
        stream(984, 983, 3, 32'h0, -1);
        chk("s2_ce_early", 32'(ce_seen), 0);
        chk("s2_ce", 32'(conv_enable), 1);
        rd(500, 32'd500, "s2_rd500");
        rd(785, 32'd785, "s2_rd785");
        pulse_clear();

        pulse_start();
        stream(501, 500, 0, 32'hF0F0_0000, -1);
        chk("s3_error", 32'(error), 1);
        chk("s3_ready", 32'(bus.in_ready), 0);
        chk("s3_ce", 32'(conv_enable), 0);
        rd(500, 32'hF0F0_01F4, "s3_rd500");
        beat(32'hDEAD_BEEF, 1'b0);
        rd(501, 32'd501, "s3_no_write_in_err");
        pulse_clear();
        chk("s3_clear_err", 32'(error), 0);
        chk("s3_idle_busy", 32'(busy), 0);
        pulse_start();
        stream(984, 983, 0, 32'h0, -1);
        chk("s3_reload_ce", 32'(conv_enable), 1);
        pulse_clear();

        start = 1'b1; clear = 1'b1;
        cyc();
        start = 1'b0; clear = 1'b0;
        chk("s4_start_wins", 32'(busy), 1);
        stream(984, -1, 0, 32'h0, -1);
        chk("s4_error", 32'(error), 1);
        chk("s4_ce", 32'(conv_enable), 0);
        pulse_clear();

        pulse_start();
        stream(301, -1, 0, 32'h1000_0000, -1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("s5_busy", 32'(busy), 0);
        chk("s5_ready", 32'(bus.in_ready), 0);
        pulse_start();
        stream(984, 983, 0, 32'h0, 100);
        chk("s5_ce", 32'(conv_enable), 1);
        chk("s5_err", 32'(error), 0);
        rd(100, 32'd100, "s5_rd100");
        rd(300, 32'd300, "s5_rd300");
        pulse_clear();

        pulse_start();
        stream(10, -1, 0, 32'h0, -1);
        beat(32'hAAAA_AAAA, 1'b1);
        chk("s6_prep_err", 32'(error), 1);
        pulse_clear();
        pulse_start();
        stream(10, -1, 0, 32'h0, -1);
        bus.rd_en   = 1'b1;
        bus.rd_addr = 10'd10;
        beat(32'h5555_5555, 1'b0);
        bus.rd_en = 1'b0;
        chk("s6_collision_old", bus.rd_data, 32'hAAAA_AAAA);
        rd(10, 32'h5555_5555, "s6_rd_new");
        chk("s6_busy", 32'(busy), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
